// File: rtl/spi_slave_receiver.sv
// SPI slave receiver: oversamples SCK/CS/MOSI on clk_100 and shifts MSB-first words; valid rises P_SYNC_STAGES+1 cycles after the final sample edge.
// The master cannot be stalled, so a word completing while valid&&!ready is dropped with an overrun pulse. Defining SPI_RX_FRAME_ERR_EN adds frame_err.
module spi_slave_receiver #(
  parameter int P_DATA_WIDTH  = 8,
  parameter int P_CS_POLAR    = 0,
  parameter int P_CPOL        = 0,
  parameter int P_CPHA        = 0,
  parameter int P_SYNC_STAGES = 2
) (
  input  logic                    clk_100,
  input  logic                    a_rst,
  input  logic                    s_rst,
  input  logic                    SCK,
  input  logic                    CS,
  input  logic                    MOSI,
  output logic [P_DATA_WIDTH-1:0] data,
  output logic                    valid,
  input  logic                    ready,
  output logic                    busy,
  output logic                    overrun
`ifdef SPI_RX_FRAME_ERR_EN
  ,
  output logic                    frame_err
`endif
);

  localparam int W     = P_DATA_WIDTH;
  localparam int S     = P_SYNC_STAGES;
  localparam int CNT_W = $clog2(W);

  localparam logic SCK_IDLE    = (P_CPOL != 0);
  localparam logic CS_ACT      = (P_CS_POLAR != 0);
  localparam logic CS_IDLE     = !CS_ACT;
  localparam logic SAMPLE_RISE = (P_CPOL == P_CPHA);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [S-1:0]     sck_sync_q, sck_sync_d;
  logic [S-1:0]     cs_sync_q, cs_sync_d;
  logic [S-1:0]     mosi_sync_q, mosi_sync_d;
  logic [S-1:0]     fill_q, fill_d;
  logic             sck_hist_q, sck_hist_d;
  logic             cs_hist_q, cs_hist_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-1:0]     shift_reg_q, shift_reg_d;
  logic [W-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
`ifdef SPI_RX_FRAME_ERR_EN
  logic             frame_err_q, frame_err_d;
`endif

  logic         sck_s, cs_s, mosi_s;
  logic         cs_act_s, cs_act_h;
  logic         cs_rise, cs_fall;
  logic         sck_rise, sck_fall;
  logic         sample_edge;
  logic         primed;
  logic         word_done;
  logic [W-1:0] word_next;

  // Synchronizers and edge detection
  always_comb begin
    sck_sync_d  = {sck_sync_q[S-2:0], SCK};
    cs_sync_d   = {cs_sync_q[S-2:0], CS};
    mosi_sync_d = {mosi_sync_q[S-2:0], MOSI};
    fill_d      = {fill_q[S-2:0], 1'b1};

    sck_s  = sck_sync_q[S-1];
    cs_s   = cs_sync_q[S-1];
    mosi_s = mosi_sync_q[S-1];

    sck_hist_d = sck_s;
    cs_hist_d  = cs_s;

    cs_act_s = (cs_s == CS_ACT);
    cs_act_h = (cs_hist_q == CS_ACT);
    cs_rise  = cs_act_s && !cs_act_h;
    cs_fall  = !cs_act_s && cs_act_h;

    sck_rise    = sck_s && !sck_hist_q;
    sck_fall    = !sck_s && sck_hist_q;
    sample_edge = cs_act_s && (SAMPLE_RISE ? sck_rise : sck_fall);

    // The idle level seeded by reset is not a real pin observation; arm only
    // once the chain has been refilled, so a CS held active through reset is not joined.
    primed  = fill_q[S-1];
    armed_d = armed_q || (primed && !cs_act_s);
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cs_rise && armed_q) state_d = ST_SHIFT;
      ST_SHIFT: if (cs_fall) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == ST_SHIFT);
  end

  // Shift register, word completion and output handshake
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_reg_d = shift_reg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    word_done   = 1'b0;
    word_next   = {shift_reg_q[W-2:0], mosi_s};

    if (state_q == ST_SHIFT) begin
      if (cs_fall) begin
        bit_cnt_d = '0;
      end else if (sample_edge) begin
        shift_reg_d = word_next;
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = '0;
          word_done = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
    end else begin
      bit_cnt_d = '0;
    end

    if (word_done) begin
      if (!valid_q || ready) begin
        data_d  = word_next;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

`ifdef SPI_RX_FRAME_ERR_EN
  always_comb begin
    frame_err_d = (state_q == ST_SHIFT) && cs_fall && (bit_cnt_q != '0);
  end
`endif

  // FSM: state register
  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      state_q <= ST_IDLE;
    end else if (s_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      sck_sync_q  <= {S{SCK_IDLE}};
      cs_sync_q   <= {S{CS_IDLE}};
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sck_hist_q  <= SCK_IDLE;
      cs_hist_q   <= CS_IDLE;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      shift_reg_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (s_rst) begin
      sck_sync_q  <= {S{SCK_IDLE}};
      cs_sync_q   <= {S{CS_IDLE}};
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sck_hist_q  <= SCK_IDLE;
      cs_hist_q   <= CS_IDLE;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      shift_reg_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      fill_q      <= fill_d;
      sck_hist_q  <= sck_hist_d;
      cs_hist_q   <= cs_hist_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_reg_q <= shift_reg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SPI_RX_FRAME_ERR_EN
  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      frame_err_q <= 1'b0;
    end else if (s_rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Bench for spi_slave_receiver: a behavioural SPI master drives one default-mode instance
// plus three instances in the other CPOL/CPHA modes; expected words come from a queue model.
`timescale 1ns/1ps
module tb_spi_slave_receiver;

  localparam int S = 2;

  logic       clk_100 = 1'b0;
  logic       a_rst, s_rst, sck, cs, mosi, ready;
  logic [7:0] data;
  logic       valid, busy, overrun;
  logic [7:0] m1_d, m2_d, m3_d;
  logic       m1_v, m2_v, m3_v, m1_b, m2_b, m3_b, m1_o, m2_o, m3_o;
`ifdef SPI_RX_FRAME_ERR_EN
  logic       frame_err, m1_f, m2_f, m3_f;
`endif

  always #5 clk_100 = ~clk_100;

  spi_slave_receiver dut (
    .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst), .SCK(sck), .CS(cs), .MOSI(mosi),
    .data(data), .valid(valid), .ready(ready), .busy(busy), .overrun(overrun)
`ifdef SPI_RX_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  spi_slave_receiver #(.P_CPOL(0), .P_CPHA(1)) dut_m1 (
    .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst), .SCK(sck), .CS(cs), .MOSI(mosi),
    .data(m1_d), .valid(m1_v), .ready(1'b1), .busy(m1_b), .overrun(m1_o)
`ifdef SPI_RX_FRAME_ERR_EN
    , .frame_err(m1_f)
`endif
  );

  spi_slave_receiver #(.P_CPOL(1), .P_CPHA(0)) dut_m2 (
    .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst), .SCK(sck), .CS(cs), .MOSI(mosi),
    .data(m2_d), .valid(m2_v), .ready(1'b1), .busy(m2_b), .overrun(m2_o)
`ifdef SPI_RX_FRAME_ERR_EN
    , .frame_err(m2_f)
`endif
  );

  spi_slave_receiver #(.P_CPOL(1), .P_CPHA(1)) dut_m3 (
    .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst), .SCK(sck), .CS(cs), .MOSI(mosi),
    .data(m3_d), .valid(m3_v), .ready(1'b1), .busy(m3_b), .overrun(m3_o)
`ifdef SPI_RX_FRAME_ERR_EN
    , .frame_err(m3_f)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  int         cyc = 0;
  logic [7:0] got[$];
  int         ovr_cnt = 0, ferr_cnt = 0, busy_gap = 0, stab_err = 0;
  int         rise_cyc = 0;
  int         m_cnt [0:3];
  logic [7:0] m_last[0:3];
  logic       valid_p = 1'b0, ready_p = 1'b0, rst_p = 1'b1;
  logic [7:0] data_p = '0;

  logic [7:0] tx_w [0:15];
  logic       chk_busy = 1'b0;
  int         last_edge_cyc = 0, cs_off_cyc = 0;

  always @(posedge clk_100) cyc <= cyc + 1;

  // Observers sample on the falling edge, between DUT updates
  initial begin
    for (int k = 0; k < 4; k++) begin
      m_cnt[k]  = 0;
      m_last[k] = '0;
    end
    forever begin
      @(negedge clk_100);
      if (valid && ready) got.push_back(data);
      if (overrun) ovr_cnt++;
`ifdef SPI_RX_FRAME_ERR_EN
      if (frame_err) ferr_cnt++;
`endif
      if (valid && !valid_p) rise_cyc = cyc;
      if (!a_rst && !s_rst && !rst_p && valid_p && !ready_p && data !== data_p) stab_err++;
      if (chk_busy && !busy) busy_gap++;
      if (valid && ready) begin m_cnt[0]++; m_last[0] = data; end
      if (m1_v) begin m_cnt[1]++; m_last[1] = m1_d; end
      if (m2_v) begin m_cnt[2]++; m_last[2] = m2_d; end
      if (m3_v) begin m_cnt[3]++; m_last[3] = m3_d; end
      valid_p = valid;
      ready_p = ready;
      data_p  = data;
      rst_p   = a_rst | s_rst;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100);
      #1;
    end
  endtask

  // Behavioural SPI master: nbits from tx_w, MSB-first, returns right after CS deasserts
  task automatic send_frame(input logic cpol, input logic cpha, input int nbits, input int half);
    logic b;
    sck = cpol;
    tick(half);
    cs = 1'b0;
    tick(half);
    for (int i = 0; i < nbits; i++) begin
      b = tx_w[i / 8][7 - (i % 8)];
      if (!cpha) begin
        mosi = b;
        tick(half);
        sck = ~cpol;
        last_edge_cyc = cyc;
        if (i == 0) chk_busy = 1'b1;
        tick(half);
        sck = cpol;
      end else begin
        sck  = ~cpol;
        mosi = b;
        tick(half);
        if (i == 0) chk_busy = 1'b1;
        sck = cpol;
        last_edge_cyc = cyc;
        tick(half);
      end
    end
    tick(half);
    chk_busy   = 1'b0;
    cs         = 1'b1;
    cs_off_cyc = cyc;
  endtask

  task automatic test_reset;
    tick(3);
    n_chk++; if (data !== 8'h00) $display("FAIL reset_data got=%h exp=00", data); else n_pass++;
    n_chk++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else n_pass++;
    a_rst = 1'b0;
    tick(10);
  endtask

  task automatic test_mode0;
    int base, ob, d;
    base = got.size(); ob = ovr_cnt;
    ready = 1'b1;
    tx_w[0] = 8'hA5;
    send_frame(1'b0, 1'b0, 8, 5);
    d = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_100);
      if (!busy) begin d = cyc - cs_off_cyc; break; end
    end
    n_chk++; if (!(d >= 0 && d <= 4)) $display("FAIL mode0_busy_fall got=%0d exp=0..4", d); else n_pass++;
    tick(20);
    n_chk++; if (got.size() - base !== 1) $display("FAIL mode0_count got=%0d exp=1", got.size() - base); else n_pass++;
    if (got.size() > base) begin
      n_chk++; if (got[base] !== 8'hA5) $display("FAIL mode0_data got=%h exp=a5", got[base]); else n_pass++;
    end
    n_chk++; if (rise_cyc - last_edge_cyc < S + 1 || rise_cyc - last_edge_cyc > S + 2)
      $display("FAIL mode0_latency got=%0d exp=%0d..%0d", rise_cyc - last_edge_cyc, S + 1, S + 2); else n_pass++;
    n_chk++; if (ovr_cnt !== ob) $display("FAIL mode0_overrun got=%0d exp=0", ovr_cnt - ob); else n_pass++;
  endtask

  task automatic test_modes;
    int base;
    for (int m = 0; m < 4; m++) begin
      ready = 1'b1;
      sck = (m >= 2);
      tick(10);
      base = m_cnt[m];
      tx_w[0] = 8'h3C;
      send_frame(m >= 2, (m % 2) == 1, 8, 4);
      tick(20);
      n_chk++; if (m_cnt[m] - base !== 1) $display("FAIL mode%0d_count got=%0d exp=1", m, m_cnt[m] - base); else n_pass++;
      n_chk++; if (m_last[m] !== 8'h3C) $display("FAIL mode%0d_data got=%h exp=3c", m, m_last[m]); else n_pass++;
    end
    sck = 1'b0;
    tick(10);
  endtask

  task automatic test_back_to_back;
    int base, gb;
    logic [7:0] exp_w[$];
    base = got.size(); gb = busy_gap;
    exp_w = '{8'h12, 8'h34, 8'h56};
    for (int k = 0; k < 3; k++) tx_w[k] = exp_w[k];
    send_frame(1'b0, 1'b0, 24, 4);
    tick(20);
    n_chk++; if (got.size() - base !== 3) $display("FAIL b2b_count got=%0d exp=3", got.size() - base); else n_pass++;
    for (int k = 0; k < 3 && base + k < got.size(); k++) begin
      n_chk++; if (got[base + k] !== exp_w[k]) $display("FAIL b2b_word%0d got=%h exp=%h", k, got[base + k], exp_w[k]); else n_pass++;
    end
    n_chk++; if (busy_gap !== gb) $display("FAIL b2b_busy_gap got=%0d exp=0", busy_gap - gb); else n_pass++;
  endtask

  task automatic test_random;
    int base, n, half;
    logic [7:0] exp_w[$];
    base = got.size();
    for (int f = 0; f < 5; f++) begin
      n    = $urandom_range(1, 4);
      half = $urandom_range(S + 1, 7);
      for (int k = 0; k < n; k++) begin
        tx_w[k] = 8'($urandom);
        exp_w.push_back(tx_w[k]);
      end
      send_frame(1'b0, 1'b0, 8 * n, half);
      tick(4 * half);
    end
    tick(10);
    n_chk++; if (got.size() - base !== exp_w.size()) $display("FAIL rand_count got=%0d exp=%0d", got.size() - base, exp_w.size()); else n_pass++;
    for (int k = 0; k < exp_w.size() && base + k < got.size(); k++) begin
      n_chk++; if (got[base + k] !== exp_w[k]) $display("FAIL rand_word%0d got=%h exp=%h", k, got[base + k], exp_w[k]); else n_pass++;
    end
  endtask

  task automatic test_overrun;
    int base, ob, sb;
    base = got.size(); ob = ovr_cnt; sb = stab_err;
    ready = 1'b0;
    tx_w[0] = 8'h11; tx_w[1] = 8'h22;
    send_frame(1'b0, 1'b0, 16, 4);
    tick(10);
    n_chk++; if (valid !== 1'b1) $display("FAIL ovr_valid_held got=%b exp=1", valid); else n_pass++;
    n_chk++; if (data !== 8'h11) $display("FAIL ovr_data_held got=%h exp=11", data); else n_pass++;
    n_chk++; if (ovr_cnt - ob !== 1) $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - ob); else n_pass++;
    ready = 1'b1;
    tick(2);
    n_chk++; if (valid !== 1'b0) $display("FAIL ovr_valid_drop got=%b exp=0", valid); else n_pass++;
    tick(20);
    n_chk++; if (got.size() - base !== 1) $display("FAIL ovr_count got=%0d exp=1", got.size() - base); else n_pass++;
    if (got.size() > base) begin
      n_chk++; if (got[base] !== 8'h11) $display("FAIL ovr_word got=%h exp=11", got[base]); else n_pass++;
    end
    n_chk++; if (stab_err !== sb) $display("FAIL ovr_data_stable got=%0d exp=0", stab_err - sb); else n_pass++;
  endtask

  task automatic test_partial;
    int base, fb;
    base = got.size(); fb = ferr_cnt;
    ready = 1'b1;
    tx_w[0] = 8'($urandom);
    send_frame(1'b0, 1'b0, 5, 4);
    tick(16);
    tx_w[0] = 8'h81;
    send_frame(1'b0, 1'b0, 8, 4);
    tick(20);
    n_chk++; if (got.size() - base !== 1) $display("FAIL partial_count got=%0d exp=1", got.size() - base); else n_pass++;
    if (got.size() > base) begin
      n_chk++; if (got[base] !== 8'h81) $display("FAIL partial_word got=%h exp=81", got[base]); else n_pass++;
    end
`ifdef SPI_RX_FRAME_ERR_EN
    n_chk++; if (ferr_cnt - fb !== 1) $display("FAIL partial_frame_err got=%0d exp=1", ferr_cnt - fb); else n_pass++;
`else
    n_chk++; if (ferr_cnt !== fb) $display("FAIL partial_frame_err got=%0d exp=0", ferr_cnt - fb); else n_pass++;
`endif
  endtask

  task automatic test_sync_reset;
    ready = 1'b0;
    tx_w[0] = 8'hC3;
    send_frame(1'b0, 1'b0, 8, 4);
    tick(10);
    n_chk++; if (valid !== 1'b1) $display("FAIL srst_pre_valid got=%b exp=1", valid); else n_pass++;
    s_rst = 1'b1;
    tick(1);
    n_chk++; if (valid !== 1'b0) $display("FAIL srst_valid got=%b exp=0", valid); else n_pass++;
    n_chk++; if (data !== 8'h00) $display("FAIL srst_data got=%h exp=00", data); else n_pass++;
    s_rst = 1'b0;
    ready = 1'b1;
    tick(10);
  endtask

  task automatic test_reset_midframe;
    int base;
    ready = 1'b0;
    tx_w[0] = 8'h5A;
    send_frame(1'b0, 1'b0, 8, 4);
    tick(10);
    for (int k = 0; k < 3; k++) tx_w[k] = 8'($urandom);
    fork
      send_frame(1'b0, 1'b0, 24, 4);
      begin
        tick(4 + 4 + 8 * 3 + 4);
        a_rst = 1'b1;
        #1;
        n_chk++; if (valid !== 1'b0) $display("FAIL arst_valid got=%b exp=0", valid); else n_pass++;
        n_chk++; if (data !== 8'h00) $display("FAIL arst_data got=%h exp=00", data); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL arst_busy got=%b exp=0", busy); else n_pass++;
        tick(1);
        a_rst = 1'b0;
        ready = 1'b1;
      end
    join
    base = got.size();
    tick(20);
    n_chk++; if (got.size() - base !== 0) $display("FAIL arst_ignored got=%0d exp=0", got.size() - base); else n_pass++;
    tx_w[0] = 8'h7E;
    send_frame(1'b0, 1'b0, 8, 4);
    tick(20);
    n_chk++; if (got.size() - base !== 1) $display("FAIL arst_next_count got=%0d exp=1", got.size() - base); else n_pass++;
    if (got.size() > base) begin
      n_chk++; if (got[base] !== 8'h7E) $display("FAIL arst_next_word got=%h exp=7e", got[base]); else n_pass++;
    end
  endtask

  initial begin
    a_rst = 1'b1; s_rst = 1'b0;
    sck = 1'b0; cs = 1'b1; mosi = 1'b0; ready = 1'b1;
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_random();
    test_overrun();
    test_partial();
    test_sync_reset();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
